// File: rtl/scc_4lc_decoder.sv
// -----------------------------------------------------------------------------
// scc_4lc_decoder
//   Read-path decoder for a 71-bit shortened Hamming (127,120) codeword that
//   carries 64 data bits and 7 check bits. The syndrome is computed from the
//   incoming codeword. A syndrome that names a codeword position (1..71) flips
//   that bit. A syndrome beyond the codeword length (72..127) is flagged as
//   detected-uncorrectable. The decoded data and the error class are
//   registered, so latency is one cycle and a new codeword is taken every
//   cycle.
//
// Ports
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous, active-high reset; clears both outputs
//   codeword    in   71  received codeword; bit j sits at position j+1
//   message     out  64  corrected data, registered
//   error_type  out  2   00 no error, 01 corrected, 10 detected uncorrectable
// -----------------------------------------------------------------------------
module scc_4lc_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic [70:0] codeword,
   output logic [63:0] message,
   output logic [1:0]  error_type
);

   typedef enum logic [1:0] {
      ERR_NONE   = 2'b00,
      ERR_CORR   = 2'b01,
      ERR_UNCORR = 2'b10
   } err_class_t;

   // Returns the codeword index of message bit i. Data fills every position
   // that is not a power of two, in ascending order. Position p is a power of
   // two exactly when (p & (p-1)) == 0. With index j and p = j+1, that test is
   // ((j+1) & j) == 0.
   function automatic int data_index(input int i);
      int cnt;
      int res;
      cnt = 0;
      res = 0;
      for (int j = 0; j < 71; j++) begin
         if (((j + 1) & j) != 0) begin
            if (cnt == i) res = j;
            cnt++;
         end
      end
      return res;
   endfunction

   logic [6:0]  syndrome;
   logic [70:0] corrected;
   logic [63:0] message_next;
   err_class_t  err_class;

   // Syndrome bit k covers every position whose binary index has bit k set.
   always_comb begin
      // NOTE: each variable gets a default before any conditional update. If
      // one path left it unassigned, synthesis would infer a latch.
      syndrome = '0;
      for (int j = 0; j < 71; j++) begin
         for (int k = 0; k < 7; k++) begin
            if ((((j + 1) >> k) & 1) != 0) syndrome[k] = syndrome[k] ^ codeword[j];
         end
      end
   end

   // A syndrome of 1..71 names a position to flip. Check-bit positions also
   // land here: they report "corrected" but do not change any data bit.
   always_comb begin
      corrected = codeword;
      err_class = ERR_NONE;
      if (syndrome == 7'd0) begin
         err_class = ERR_NONE;
      end else if (syndrome <= 7'd71) begin
         corrected[syndrome - 7'd1] = ~codeword[syndrome - 7'd1];
         err_class = ERR_CORR;
      end else begin
         err_class = ERR_UNCORR;
      end
   end

   // The data bits are extracted through fixed wiring. Every index is a
   // constant, so no logic is generated.
   for (genvar i = 0; i < 64; i++) begin : g_extract
      localparam int Idx = data_index(i);
      assign message_next[i] = corrected[Idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: registers use non-blocking assignments. Every flop then updates
      // from values sampled at the same edge, and simulation matches the
      // synthesised hardware.
      if (rst) begin
         message    <= '0;
         error_type <= ERR_NONE;
      end else begin
         message    <= message_next;
         error_type <= err_class;
      end
   end

endmodule

// File: tb/tb_scc_4lc_decoder.sv
// -----------------------------------------------------------------------------
// tb_scc_4lc_decoder
//   Self-checking bench for scc_4lc_decoder. It runs directed cases, random
//   single-error and random raw codewords, a back-to-back stream and a
//   mid-stream reset. Expected values come from a reference model. In that
//   model, the syndrome is the XOR of the positions of all set bits, and the
//   data positions are held in a queue.
// -----------------------------------------------------------------------------
module tb_scc_4lc_decoder;

   logic        clk;
   logic        rst;
   logic [70:0] codeword;
   logic [63:0] message;
   logic [1:0]  error_type;

   int tests_run = 0;
   int tests_failed = 0;

   scc_4lc_decoder dut (
      .clk        (clk),
      .rst        (rst),
      .codeword   (codeword),
      .message    (message),
      .error_type (error_type)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int data_pos[$];   // codeword index of each message bit, in order

   function automatic int model_syndrome(input logic [70:0] cw);
      int s;
      s = 0;
      for (int j = 0; j < 71; j++) if (cw[j]) s = s ^ (j + 1);
      return s;
   endfunction

   function automatic void model_decode(input logic [70:0] cw,
                                        output logic [63:0] msg,
                                        output logic [1:0] et);
      int s;
      logic [70:0] c;
      s = model_syndrome(cw);
      c = cw;
      if (s == 0) et = 2'b00;
      else if (s <= 71) begin
         c[s - 1] = ~c[s - 1];
         et = 2'b01;
      end else et = 2'b10;
      msg = '0;
      for (int m = 0; m < 64; m++) msg[m] = c[data_pos[m]];
   endfunction

   // Builds a valid codeword. The data bits are placed first. Each check bit
   // is then set to cancel the matching syndrome bit.
   function automatic logic [70:0] model_encode(input logic [63:0] data);
      logic [70:0] cw;
      int s;
      cw = '0;
      for (int m = 0; m < 64; m++) cw[data_pos[m]] = data[m];
      s = model_syndrome(cw);
      for (int k = 0; k < 7; k++) if (((s >> k) & 1) != 0) cw[(1 << k) - 1] = 1'b1;
      return cw;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive_and_check(input logic [70:0] cw, input logic [63:0] exp_msg,
                                  input logic [1:0] exp_et, input string name);
      codeword = cw;
      @(posedge clk);
      #1;
      tests_run++;
      if (message !== exp_msg || error_type !== exp_et) begin
         tests_failed++;
         $display("FAIL %s: got msg=%h et=%b, expected msg=%h et=%b",
                  name, message, error_type, exp_msg, exp_et);
      end
   endtask

   task automatic drive_model(input logic [70:0] cw, input string name);
      logic [63:0] em;
      logic [1:0]  ee;
      model_decode(cw, em, ee);
      drive_and_check(cw, em, ee, name);
   endtask

   function automatic logic [70:0] rand_cw();
      return {7'($urandom), $urandom, $urandom};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      codeword = rand_cw();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);       // one decode loaded, so outputs are likely nonzero
      codeword = {71{1'b1}};
      @(posedge clk);
      #2;
      rst = 1'b1;           // between edges: the clear must be asynchronous
      #1;
      tests_run++;
      if (message !== 64'h0 || error_type !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset: got msg=%h et=%b, expected msg=0 et=00", message, error_type);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      drive_and_check(71'h7, 64'h1, 2'b00, "clean_h7");
      drive_and_check(71'h0, 64'h0, 2'b00, "all_zero");
      drive_and_check(71'h1 << 70, 64'h0, 2'b01, "single_b70");
      // Positions 71 and 70 give syndrome 1, so check bit 0 is flipped.
      // Data positions 70 and 71 (message bits 62 and 63) stay set.
      drive_and_check((71'h1 << 70) | (71'h1 << 69), 64'hC000_0000_0000_0000, 2'b01, "pair_70_69");
      // Positions 71 and 65 give syndrome 6. Message bit 2 is set by the
      // correction, and message bits 63 and 57 stay set.
      drive_and_check((71'h1 << 70) | (71'h1 << 64), 64'h8200_0000_0000_0004, 2'b01, "pair_70_64");
      // Positions 71, 65 and 64 give syndrome 70. Message bit 62 is set by
      // the correction.
      drive_and_check((71'h1 << 70) | (71'h1 << 64) | (71'h1 << 63),
                      64'hC200_0000_0000_0000, 2'b01, "triple_70_64_63");
      drive_and_check((71'h1 << 63) | (71'h1 << 7), 64'h0, 2'b10, "uncorr_63_7");
      drive_and_check((71'h1 << 63) | (71'h1 << 7) | 71'h4, 64'h1, 2'b10, "uncorr_with_data");
      // Flipping check bit 3 (position 8) reports corrected, but the data is unchanged.
      drive_and_check(71'h1 << 7, 64'h0, 2'b01, "check_bit_only");
   endtask

   task automatic test_single_error();
      logic [63:0] data;
      logic [70:0] cw;
      int pos;
      for (int n = 0; n < 100; n++) begin
         data = {$urandom, $urandom};
         cw = model_encode(data);
         if (n % 4 != 0) begin
            pos = int'($urandom_range(70, 0));
            cw[pos] = ~cw[pos];
            drive_and_check(cw, data, 2'b01, "rand_single");
         end else begin
            drive_and_check(cw, data, 2'b00, "rand_clean");
         end
      end
   endtask

   task automatic test_random_raw();
      for (int n = 0; n < 150; n++) drive_model(rand_cw(), "rand_raw");
   endtask

   task automatic test_back_to_back();
      // Each driven codeword is checked right after the edge that samples it.
      // No idle cycles are inserted, so every output must belong to the
      // codeword of the previous cycle.
      for (int n = 0; n < 40; n++) drive_model(rand_cw(), "back_to_back");
   endtask

   task automatic test_mid_stream_reset();
      for (int n = 0; n < 5; n++) drive_model(rand_cw(), "pre_reset_stream");
      // This codeword has syndrome 70 and an uncorrectable-free decode with
      // nonzero data, so the clear is visible.
      drive_and_check((71'h1 << 70) | (71'h1 << 64) | (71'h1 << 63),
                      64'hC200_0000_0000_0000, 2'b01, "pre_reset_value");
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if (message !== 64'h0 || error_type !== 2'b00) begin
         tests_failed++;
         $display("FAIL mid_reset: got msg=%h et=%b, expected msg=0 et=00", message, error_type);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (message !== 64'h0 || error_type !== 2'b00) begin
         tests_failed++;
         $display("FAIL mid_reset_hold: got msg=%h et=%b, expected msg=0 et=00", message, error_type);
      end
      @(negedge clk);
      rst = 1'b0;
      drive_model(rand_cw(), "post_reset_first");
      drive_model(rand_cw(), "post_reset_second");
   endtask

   initial begin
      for (int p = 1; p <= 71; p++) if ((p & (p - 1)) != 0) data_pos.push_back(p - 1);
      rst = 1'b1;
      codeword = '0;
      test_reset();
      test_directed();
      test_single_error();
      test_random_raw();
      test_back_to_back();
      test_mid_stream_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
